// File: rtl/ctrl_pkg.sv
// Shared constants, defaults and FSM encoding for the controller frame receiver.
package ctrl_pkg;

  localparam logic [7:0] START_BYTE = 8'hFF;
  localparam logic [7:0] AXIS_RESET = 8'h80;

  localparam int unsigned DEF_NUM_CH       = 2;
  localparam int unsigned DEF_NUM_BTN      = 8;
  localparam int unsigned DEF_NUM_AXES     = 2;
  localparam int unsigned DEF_GAP_TIMEOUT  = 100000;
  localparam int unsigned DEF_STALE_CYCLES = 2000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHANNEL,
    ST_BUTTONS,
    ST_AXES,
    ST_CHECK
  } rx_state_e;

endpackage

// File: rtl/ctrl_frame_rx_if.sv
// Byte stream from the SPI byte receiver into the frame parser.
interface ctrl_frame_rx_if;

  logic [7:0] byte_in;
  logic       byte_valid_in;

  modport master (output byte_in, output byte_valid_in);
  modport slave  (input  byte_in, input  byte_valid_in);

endinterface

// File: rtl/ctrl_chan_regs.sv
// Committed button/axis registers for one channel plus its staleness tracking.
module ctrl_chan_regs
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_BTN      = DEF_NUM_BTN,
  parameter int unsigned NUM_AXES     = DEF_NUM_AXES,
  parameter int unsigned STALE_CYCLES = DEF_STALE_CYCLES
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     commit_in,
  input  logic [NUM_BTN-1:0]       btn_in,
  input  logic [NUM_AXES-1:0][7:0] ax_in,
  output logic [NUM_BTN-1:0]       buttons_out,
  output logic [NUM_AXES-1:0][7:0] axes_out,
  output logic                     update_out,
  output logic                     connected_out
);

  localparam int unsigned CNT_W = $clog2(STALE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STALE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALE_CYCLES - 1);

  logic [CNT_W-1:0] stale_q;
  logic             seen_q;

  // Atomic copy of the shadow on commit; update pulse lands with the new data.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      buttons_out <= '0;
      axes_out    <= {NUM_AXES{AXIS_RESET}};
      update_out  <= 1'b0;
    end else begin
      update_out <= commit_in;
      if (commit_in) begin
        buttons_out <= btn_in;
        axes_out    <= ax_in;
      end
    end
  end

  // Saturating age counter; connected tracks (seen && age < limit) after each edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      stale_q       <= '0;
      seen_q        <= 1'b0;
      connected_out <= 1'b0;
    end else if (commit_in) begin
      stale_q       <= '0;
      seen_q        <= 1'b1;
      connected_out <= 1'b1;
    end else begin
      if (stale_q != CNT_SAT) begin
        stale_q <= stale_q + CNT_W'(1);
      end
      connected_out <= seen_q && (stale_q < CNT_LAST);
    end
  end

endmodule

// File: rtl/ctrl_frame_rx.sv
// Parses start/channel/buttons/axes/checksum frames and commits them per channel.
module ctrl_frame_rx
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned NUM_BTN      = DEF_NUM_BTN,
  parameter int unsigned NUM_AXES     = DEF_NUM_AXES,
  parameter int unsigned GAP_TIMEOUT  = DEF_GAP_TIMEOUT,
  parameter int unsigned STALE_CYCLES = DEF_STALE_CYCLES
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  ctrl_frame_rx_if.slave                       rx_bus,
  output logic [NUM_CH-1:0][NUM_BTN-1:0]       buttons_out,
  output logic [NUM_CH-1:0][NUM_AXES-1:0][7:0] axes_out,
  output logic [NUM_CH-1:0]                    update_out,
  output logic [NUM_CH-1:0]                    connected_out,
  output logic                                 csum_err_out,
  output logic                                 chan_err_out,
  output logic                                 timeout_err_out,
  output logic [7:0]                           last_raw_byte_out
);

  localparam int unsigned BTN_BYTES = NUM_BTN / 8;
  localparam int unsigned AX_W      = NUM_AXES * 8;
  localparam int unsigned GAP_W     = $clog2(GAP_TIMEOUT + 1);
  localparam logic [7:0]       NUM_CH_B = 8'(NUM_CH);
  localparam logic [2:0]       BTN_LAST = 3'(BTN_BYTES - 1);
  localparam logic [2:0]       AX_LAST  = 3'(NUM_AXES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  rx_state_e                state_q, state_d;
  logic [2:0]               idx_q;
  logic [7:0]               chan_q;
  logic [7:0]               csum_q;
  logic [GAP_W-1:0]         gap_q;
  logic [NUM_BTN-1:0]       shadow_btn_q;
  logic [NUM_AXES-1:0][7:0] shadow_ax_q;

  logic       valid;
  logic [7:0] data;
  logic       timeout_c, commit_c, csum_err_c, chan_err_c;

  assign valid     = rx_bus.byte_valid_in;
  assign data      = rx_bus.byte_in;
  assign timeout_c = (state_q != ST_IDLE) && !valid && (gap_q == GAP_LAST);

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state: advance only on accepted bytes; a coinciding byte beats the timeout.
  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = ST_IDLE;
    end else if (valid) begin
      case (state_q)
        ST_IDLE:    if (data == START_BYTE) state_d = ST_CHANNEL;
        ST_CHANNEL: state_d = (data >= NUM_CH_B) ? ST_IDLE : ST_BUTTONS;
        ST_BUTTONS: if (idx_q == BTN_LAST) state_d = ST_AXES;
        ST_AXES:    if (idx_q == AX_LAST) state_d = ST_CHECK;
        ST_CHECK:   state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Decode commit and error events from the current byte.
  always_comb begin
    commit_c   = 1'b0;
    csum_err_c = 1'b0;
    chan_err_c = 1'b0;
    if (valid) begin
      case (state_q)
        ST_CHANNEL: chan_err_c = (data >= NUM_CH_B);
        ST_CHECK: begin
          commit_c   = (data == csum_q);
          csum_err_c = (data != csum_q);
        end
        default: ;
      endcase
    end
  end

  // Registered error pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      csum_err_out    <= 1'b0;
      chan_err_out    <= 1'b0;
      timeout_err_out <= 1'b0;
    end else begin
      csum_err_out    <= csum_err_c;
      chan_err_out    <= chan_err_c;
      timeout_err_out <= timeout_c;
    end
  end

  // Shadow capture, running checksum, byte index, gap counter and debug byte.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      idx_q             <= '0;
      chan_q            <= '0;
      csum_q            <= '0;
      gap_q             <= '0;
      shadow_btn_q      <= '0;
      shadow_ax_q       <= '0;
      last_raw_byte_out <= '0;
    end else begin
      if (valid || (state_q == ST_IDLE) || timeout_c) gap_q <= '0;
      else                                             gap_q <= gap_q + GAP_W'(1);
      if (valid) begin
        last_raw_byte_out <= data;
        case (state_q)
          ST_IDLE: begin
            idx_q  <= '0;
            csum_q <= '0;
          end
          ST_CHANNEL: begin
            chan_q <= data;
            csum_q <= data;
            idx_q  <= '0;
          end
          ST_BUTTONS: begin
            // MSB byte arrives first, so shift left.
            shadow_btn_q <= NUM_BTN'({shadow_btn_q, data});
            csum_q       <= csum_q ^ data;
            idx_q        <= (idx_q == BTN_LAST) ? 3'd0 : idx_q + 3'd1;
          end
          ST_AXES: begin
            // Axis 0 arrives first, so shift right and it settles in the low slot.
            shadow_ax_q <= AX_W'({data, shadow_ax_q} >> 8);
            csum_q      <= csum_q ^ data;
            idx_q       <= idx_q + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // One committed register bank per channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ctrl_chan_regs #(
      .NUM_BTN     (NUM_BTN),
      .NUM_AXES    (NUM_AXES),
      .STALE_CYCLES(STALE_CYCLES)
    ) u_regs (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .commit_in    (commit_c && (chan_q == 8'(gi))),
      .btn_in       (shadow_btn_q),
      .ax_in        (shadow_ax_q),
      .buttons_out  (buttons_out[gi]),
      .axes_out     (axes_out[gi]),
      .update_out   (update_out[gi]),
      .connected_out(connected_out[gi])
    );
  end

endmodule

// File: tb/tb_ctrl_frame_rx.sv
// Randomized and directed checks of ctrl_frame_rx against a frame-level model.
module tb_ctrl_frame_rx;
  import ctrl_pkg::*;

  localparam int NCH   = 2;
  localparam int NBTN  = 16;
  localparam int NAX   = 2;
  localparam int GAP   = 24;
  localparam int STALE = 400;
  localparam int BB    = NBTN / 8;
  localparam int FLEN  = 1 + BB + NAX + 1;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_n_in;
  ctrl_frame_rx_if bus();

  logic [NCH-1:0][NBTN-1:0]    buttons_out;
  logic [NCH-1:0][NAX-1:0][7:0] axes_out;
  logic [NCH-1:0]              update_out;
  logic [NCH-1:0]              connected_out;
  logic                        csum_err_out, chan_err_out, timeout_err_out;
  logic [7:0]                  last_raw_byte_out;

  ctrl_frame_rx #(
    .NUM_CH(NCH), .NUM_BTN(NBTN), .NUM_AXES(NAX),
    .GAP_TIMEOUT(GAP), .STALE_CYCLES(STALE)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .rx_bus           (bus),
    .buttons_out      (buttons_out),
    .axes_out         (axes_out),
    .update_out       (update_out),
    .connected_out    (connected_out),
    .csum_err_out     (csum_err_out),
    .chan_err_out     (chan_err_out),
    .timeout_err_out  (timeout_err_out),
    .last_raw_byte_out(last_raw_byte_out)
  );

  // Frame-level reference state.
  logic [NBTN-1:0] m_btn [NCH];
  logic [7:0]      m_ax  [NCH][NAX];
  int              m_since [NCH];
  bit              m_seen  [NCH];
  bit              m_in_frame;
  logic [7:0]      m_frame [$];
  int              m_idle;
  logic [7:0]      m_last;
  logic [NCH-1:0]  m_upd;
  bit              m_cerr, m_cherr, m_terr;

  logic [7:0] tx_q [$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_btn[c] = '0;
      for (int a = 0; a < NAX; a++) m_ax[c][a] = 8'h80;
      m_since[c] = 0;
      m_seen[c]  = 1'b0;
    end
    m_in_frame = 1'b0;
    m_frame.delete();
    m_idle = 0;
    m_last = 8'h00;
    m_upd  = '0;
    m_cerr = 1'b0; m_cherr = 1'b0; m_terr = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    logic [7:0] x;
    int ch;
    m_upd = '0;
    m_cerr = 1'b0; m_cherr = 1'b0; m_terr = 1'b0;
    for (int c = 0; c < NCH; c++) if (m_since[c] < STALE) m_since[c]++;
    if (v) begin
      m_last = b;
      m_idle = 0;
      if (!m_in_frame) begin
        if (b == 8'hFF) begin
          m_in_frame = 1'b1;
          m_frame.delete();
        end
      end else begin
        m_frame.push_back(b);
        if (m_frame.size() == 1 && int'(b) >= NCH) begin
          m_cherr = 1'b1;
          m_in_frame = 1'b0;
        end else if (m_frame.size() == FLEN) begin
          x = 8'h00;
          for (int i = 0; i < FLEN - 1; i++) x ^= m_frame[i];
          if (x == m_frame[FLEN-1]) begin
            ch = int'(m_frame[0]);
            m_btn[ch] = '0;
            for (int k = 0; k < BB; k++) m_btn[ch] = {m_btn[ch][NBTN-9:0], m_frame[1+k]};
            for (int a = 0; a < NAX; a++) m_ax[ch][a] = m_frame[1+BB+a];
            m_upd[ch]   = 1'b1;
            m_since[ch] = 0;
            m_seen[ch]  = 1'b1;
          end else begin
            m_cerr = 1'b1;
          end
          m_in_frame = 1'b0;
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == GAP) begin
        m_terr = 1'b1;
        m_in_frame = 1'b0;
        m_idle = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0][NBTN-1:0]    eb;
    logic [NCH-1:0][NAX-1:0][7:0] ea;
    logic [NCH-1:0]              ec;
    for (int c = 0; c < NCH; c++) begin
      eb[c] = m_btn[c];
      for (int a = 0; a < NAX; a++) ea[c][a] = m_ax[c][a];
      ec[c] = m_seen[c] && (m_since[c] < STALE);
    end
    check("buttons",   64'(buttons_out),       64'(eb));
    check("axes",      64'(axes_out),          64'(ea));
    check("update",    64'(update_out),        64'(m_upd));
    check("connected", 64'(connected_out),     64'(ec));
    check("csum_err",  64'(csum_err_out),      64'(m_cerr));
    check("chan_err",  64'(chan_err_out),      64'(m_cherr));
    check("timeout",   64'(timeout_err_out),   64'(m_terr));
    check("last_raw",  64'(last_raw_byte_out), 64'(m_last));
  endtask

  // One clock: drive, advance model at the edge, compare 1 ns later.
  task automatic tick(input logic rst, input logic v, input logic [7:0] b);
    rst_n_in          = rst;
    bus.byte_valid_in = v;
    bus.byte_in       = b;
    @(posedge clk_in);
    if (!rst) model_reset();
    else      model_step(v, b);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0, 8'($urandom));
  endtask

  task automatic send_q(input int gap_max);
    foreach (tx_q[i]) begin
      tick(1'b1, 1'b1, tx_q[i]);
      if (i != tx_q.size() - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic rand_frame();
    logic [7:0] x, d, chb;
    int keep;
    tx_q.delete();
    tx_q.push_back(START_BYTE);
    chb = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, NCH - 1));
    tx_q.push_back(chb);
    x = chb;
    for (int k = 0; k < BB + NAX; k++) begin
      d = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
      tx_q.push_back(d);
      x ^= d;
    end
    if ($urandom_range(0, 6) == 0) x ^= 8'(1 << $urandom_range(0, 7));
    tx_q.push_back(x);
    if ($urandom_range(0, 9) == 0) begin
      keep = $urandom_range(2, FLEN);
      while (tx_q.size() > keep) void'(tx_q.pop_back());
    end
    if ($urandom_range(0, 7) == 0) begin
      foreach (tx_q[i]) begin
        tick(1'b1, 1'b1, tx_q[i]);
        if (i != tx_q.size() - 1) idle(GAP - 1);
      end
    end else begin
      send_q(3);
    end
    if ($urandom_range(0, 3) == 0) idle(GAP + 2);
    else                           idle($urandom_range(0, 3));
    repeat ($urandom_range(0, 2)) tick(1'b1, 1'b1, 8'($urandom_range(0, 254)));
  endtask

  initial begin
    rst_n_in = 1'b0;
    bus.byte_valid_in = 1'b0;
    bus.byte_in = 8'h00;
    model_reset();
    repeat (3) tick(1'b0, 1'b1, 8'h5A);
    check("rst_buttons", 64'(buttons_out), 64'h0);
    check("rst_axes",    64'(axes_out),    64'h8080_8080);
    idle(2);

    // Bad checksum leaves channel 1 at reset values.
    tx_q = '{8'hFF, 8'h01, 8'hA5, 8'h3C, 8'h10, 8'hF0, 8'h79};
    send_q(0);
    check("bad_csum_pulse", 64'(csum_err_out), 64'h1);
    check("bad_csum_btn",   64'(buttons_out[1]), 64'h0);
    idle(3);

    // Good frame to channel 1.
    tx_q = '{8'hFF, 8'h01, 8'hA5, 8'h3C, 8'h10, 8'hF0, 8'h78};
    send_q(0);
    check("good_upd",  64'(update_out),     64'h2);
    check("good_btn",  64'(buttons_out[1]), 64'hA53C);
    check("good_axes", 64'(axes_out[1]),    64'hF010);
    check("good_ch0",  64'(buttons_out[0]), 64'h0);
    idle(1);
    check("good_upd_off", 64'(update_out),      64'h0);
    check("good_conn",    64'(connected_out[1]), 64'h1);

    // Channel out of range, then a normal channel 0 frame.
    tx_q = '{8'hFF, 8'h02};
    send_q(0);
    check("chan_err_pulse", 64'(chan_err_out), 64'h1);
    tx_q = '{8'hFF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_q(1);
    check("ch0_btn", 64'(buttons_out[0]), 64'h1122);
    idle(2);

    // Gap timeout, then a byte exactly on the timeout cycle keeps the frame alive.
    tx_q = '{8'hFF, 8'h00, 8'h12};
    send_q(0);
    idle(GAP);
    check("timeout_pulse", 64'(timeout_err_out), 64'h1);
    tx_q = '{8'hFF, 8'h00, 8'h12};
    send_q(0);
    idle(GAP - 1);
    tick(1'b1, 1'b1, 8'h34);
    check("timeout_beaten", 64'(timeout_err_out), 64'h0);
    tx_q = '{8'h56, 8'h78, 8'h08};
    send_q(0);
    check("late_byte_btn", 64'(buttons_out[0]), 64'h1234);
    idle(2);

    // 0xFF as payload.
    tx_q = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    send_q(0);
    check("ff_data_btn",  64'(buttons_out[0]), 64'hFFFF);
    check("ff_data_axes", 64'(axes_out[0]),    64'h0000);
    idle(2);

    // Reset mid-frame, then a complete frame.
    tx_q = '{8'hFF, 8'h01, 8'hAA};
    send_q(0);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'hFF);
    tx_q = '{8'hFF, 8'h01, 8'hA5, 8'h3C, 8'h10, 8'hF0, 8'h78};
    send_q(2);
    check("post_rst_btn", 64'(buttons_out[1]), 64'hA53C);

    for (int f = 0; f < 120; f++) rand_frame();

    idle(STALE + 5);
    check("stale_disconnect", 64'(connected_out), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_frame_rx.md
CTRL_FRAME_RX -- requirements
Module: ctrl_frame_rx

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of controller channels (1..4).
REQ-002 SHALL have parameter NUM_BTN, default 8, buttons per channel (multiple of 8, 8..32).
REQ-003 SHALL have parameter NUM_AXES, default 2, 8-bit analog axes per channel (1..4).
REQ-004 SHALL have parameter GAP_TIMEOUT, default 100000, maximum idle cycles between bytes inside a frame.
REQ-005 SHALL have parameter STALE_CYCLES, default 2000000, cycles without a good frame before a channel is disconnected.
REQ-006 SHALL have port clk_in  input  1  the single system clock.
REQ-007 SHALL have port rst_n_in  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port byte_in  input  8  received byte from the SPI byte receiver.
REQ-009 SHALL have port byte_valid_in  input  1  one-cycle strobe qualifying byte_in.
REQ-010 SHALL have port buttons_out  output  NUM_CH x NUM_BTN  committed button state per channel.
REQ-011 SHALL have port axes_out  output  NUM_CH x NUM_AXES x 8  committed axis values per channel.
REQ-012 SHALL have port update_out  output  NUM_CH  one-cycle pulse per channel on commit.
REQ-013 SHALL have port connected_out  output  NUM_CH  channel has a good frame within STALE_CYCLES.
REQ-014 SHALL have ports csum_err_out, chan_err_out, timeout_err_out  output  1 each  one-cycle error pulses.
REQ-015 SHALL have port last_raw_byte_out  output  8  last byte accepted (debug).

Function
REQ-016 Frame SHALL be: 0xFF start, channel byte, NUM_BTN/8 button bytes (MSB byte first, bit7 = highest button), NUM_AXES axis bytes (axis 0 first), checksum byte.
REQ-017 Checksum SHALL be XOR of the channel, button and axis bytes; the start byte is excluded.
REQ-018 FSM states SHALL be IDLE, CHANNEL, BUTTONS, AXES, CHECK; transitions occur only on byte_valid_in, except timeout.
REQ-019 In IDLE, 0xFF SHALL move to CHANNEL; other bytes SHALL be ignored silently.
REQ-020 Inside a frame, 0xFF SHALL be treated as ordinary data (no resync).
REQ-021 A channel byte >= NUM_CH SHALL pulse chan_err_out and return to IDLE.
REQ-022 Button and axis bytes SHALL go to shadow registers only; committed outputs SHALL stay unchanged until CHECK.
REQ-023 In CHECK, a match SHALL copy the shadow to the addressed channel's outputs in one cycle (atomic), pulse that channel's update_out on the next cycle, and return to IDLE.
REQ-024 In CHECK, a mismatch SHALL pulse csum_err_out, leave outputs unchanged and return to IDLE.
REQ-025 Gap counter SHALL clear on every accepted byte; while not in IDLE, reaching GAP_TIMEOUT cycles without a byte SHALL pulse timeout_err_out and return to IDLE.
REQ-026 If byte_valid_in coincides with the timeout cycle, the byte SHALL win and no timeout SHALL fire.
REQ-027 Per-channel stale counter SHALL clear on commit, saturate at STALE_CYCLES, and connected_out SHALL be high iff the counter < STALE_CYCLES and at least one commit has occurred.
REQ-028 last_raw_byte_out SHALL update on every byte_valid_in, in any state.
REQ-029 Latency SHALL be: committed outputs valid the cycle after the checksum strobe; update_out high in that same cycle.

Reset
REQ-030 While rst_n_in is low at clk_in: state IDLE, buttons_out 0, axes_out 8'h80, update_out 0, connected_out 0, error pulses 0, last_raw_byte_out 0, counters 0.
REQ-031 Reset mid-frame SHALL discard the shadow; the first post-reset frame SHALL be accepted normally.

Structure
REQ-032 Shared package ctrl_pkg SHALL hold START_BYTE (8'hFF), the FSM state enum, and the default parameter values.
REQ-033 One sub-module, ctrl_chan_regs (per-channel committed registers plus stale counter), SHALL be instantiated NUM_CH times via generate.

Verification (NUM_CH=2, NUM_BTN=16, NUM_AXES=2)
REQ-034 FF 01 A5 3C 10 F0 78 -> ch1 buttons 16'hA53C, axes[0]=10, axes[1]=F0, update_out=2'b10 for one cycle, connected_out[1]=1; ch0 unchanged.
REQ-035 Same frame with checksum 79 -> csum_err_out pulse, no update_out, ch1 outputs still reset values.
REQ-036 FF 02 ... -> chan_err_out pulse; the following valid ch0 frame commits normally.
REQ-037 FF 00 12, then no byte for GAP_TIMEOUT cycles -> timeout_err_out pulse, IDLE; a byte on the exact timeout cycle -> no pulse.
REQ-038 FF 00 FF FF 00 00 00 (0xFF as data, checksum 00) -> ch0 buttons 16'hFFFF, axes 00 00.
REQ-039 rst_n_in low mid-frame, then a full frame -> outputs at reset values until commit; after STALE_CYCLES with no frames, connected_out returns to 0.
